// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and the fetch FSM state encoding
package riscv;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction memory request/response bus
interface ifetch_if;

  logic                   imem_req_o;
  logic [riscv::XLEN-1:0] imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [31:0]            imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetched-instruction buffer; flush beats push/pop, push accepted when full if popping
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign count = r_count;
  assign rdata = r_mem[r_rptr];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit: single-outstanding imem requests into a small buffer.
// IFETCH_MISALIGN_EXC_EN: misaligned redirects raise misalign_exc_o and halt fetch instead of aligning.
module ifetch
  import riscv::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            branch_v_i,
  input  logic [XLEN-1:0] pc_nxt_i,
  ifetch_if.master        imem,
  output logic            instr_v_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
`ifdef IFETCH_MISALIGN_EXC_EN
  ,
  output logic            misalign_exc_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifetch_state_e   r_state, n_state;
  logic [XLEN-1:0] r_pc, n_pc;
  logic [XLEN-1:0] r_req_pc, n_req_pc;
  logic            r_out, n_out;
  logic            r_disc, n_disc;

  logic            w_req, w_gnt, w_rsp, w_push, w_pop;
  logic            w_full, w_empty, w_halt, w_misalign;
  logic [CW-1:0]   w_count, w_cnt_nxt, w_occ;
  logic [XLEN-1:0] w_target;
  logic [31+XLEN:0] w_rdata;

`ifdef IFETCH_MISALIGN_EXC_EN
  logic r_halt, r_exc;
  assign w_misalign     = branch_v_i & (pc_nxt_i[1:0] != 2'b00);
  assign w_halt         = r_halt;
  assign w_target       = pc_nxt_i;
  assign misalign_exc_o = r_exc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_halt <= 1'b0;
      r_exc  <= 1'b0;
    end else begin
      r_exc <= w_misalign;
      if (branch_v_i) r_halt <= w_misalign;
    end
  end
`else
  assign w_misalign = 1'b0;
  assign w_halt     = 1'b0;
  assign w_target   = pc_nxt_i & ~XLEN'(3);
`endif

  // A discarded response still occupies the bus, so no new request until it returns.
  assign w_req  = (r_state == REQ) && !r_out;
  assign w_gnt  = w_req && imem.imem_gnt_i;
  assign w_rsp  = r_out && imem.imem_rvalid_i;
  assign w_push = w_rsp && !r_disc && !branch_v_i;
  assign w_pop  = instr_v_o && instr_ready_i && !branch_v_i;

  assign w_cnt_nxt = w_count + CW'(w_push) - CW'(w_pop);
  assign w_occ     = w_count + CW'(r_out);

  assign imem.imem_req_o  = w_req;
  assign imem.imem_addr_o = r_pc;
  assign instr_v_o        = !w_empty;
  assign instr_o          = w_rdata[31+XLEN:XLEN];
  assign pc_o             = w_rdata[XLEN-1:0];

  always_comb begin
    n_state  = r_state;
    n_pc     = r_pc;
    n_req_pc = r_req_pc;
    n_out    = r_out;
    n_disc   = r_disc;
    if (w_rsp) begin
      n_out  = 1'b0;
      n_disc = 1'b0;
    end
    case (r_state)
      IDLE: begin
        if (!w_halt && !w_full && (w_occ < CW'(FIFO_DEPTH))) n_state = REQ;
      end
      REQ: begin
        if (w_gnt) begin
          n_state  = WAIT_R;
          n_out    = 1'b1;
          n_req_pc = r_pc;
          n_pc     = r_pc + XLEN'(4);
        end
      end
      WAIT_R: begin
        if (w_rsp) n_state = (w_cnt_nxt < CW'(FIFO_DEPTH)) ? REQ : IDLE;
      end
      default: n_state = IDLE;
    endcase
    // Redirect wins over everything; whatever is still in flight becomes a discard.
    if (branch_v_i) begin
      n_pc    = w_target;
      n_state = w_misalign ? IDLE : REQ;
      n_disc  = n_out;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_VECTOR;
      r_req_pc <= '0;
      r_out    <= 1'b0;
      r_disc   <= 1'b0;
    end else begin
      r_state  <= n_state;
      r_pc     <= n_pc;
      r_req_pc <= n_req_pc;
      r_out    <= n_out;
      r_disc   <= n_disc;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32 + XLEN)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (branch_v_i),
    .wdata   ({imem.imem_rdata_i, r_req_pc}),
    .rdata   (w_rdata),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch with a queue-based fetch model
module tb_ifetch;
  import riscv::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            branch_v_i = 1'b0;
  logic [XLEN-1:0] pc_nxt_i = '0;
  logic            instr_v_o;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] pc_o;
  logic            instr_ready_i = 1'b0;
`ifdef IFETCH_MISALIGN_EXC_EN
  logic            misalign_exc_o;
`endif

  ifetch_if bus ();

  ifetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .branch_v_i    (branch_v_i),
    .pc_nxt_i      (pc_nxt_i),
    .imem          (bus),
    .instr_v_o     (instr_v_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
`ifdef IFETCH_MISALIGN_EXC_EN
    ,
    .misalign_exc_o(misalign_exc_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: delivered-instruction queue, one pending memory transaction, next in-order fetch address.
  logic [31:0] mq[$];
  bit          has_pend, pend_disc, prev_hold, post_br, m_halt, exp_exc, stale_rv;
  logic [31:0] pend_addr, exp_fetch, prev_addr, br_tgt;
  int          starve;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == RESET_VECTOR) ? 32'h0000_0013 : ((a ^ 32'h5A5A_0000) + 32'h3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input bit br, input logic [31:0] tgt, input bit gn, input bit rv, input bit rdy);
    bit g, rsp;
    logic [31:0] addr;
    chk("instr_v", 32'(instr_v_o), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("pc_o", pc_o, mq[0]);
      chk("instr_o", instr_o, memf(mq[0]));
    end
    if (has_pend || m_halt || mq.size() >= DEPTH) chk("req_blocked", 32'(bus.imem_req_o), 32'd0);
    if (prev_hold) begin
      chk("req_hold", 32'(bus.imem_req_o), 32'd1);
      chk("addr_hold", bus.imem_addr_o, prev_addr);
    end
    if (post_br && !has_pend && !m_halt) begin
      chk("req_after_br", 32'(bus.imem_req_o), 32'd1);
      chk("addr_after_br", bus.imem_addr_o, br_tgt);
    end
`ifdef IFETCH_MISALIGN_EXC_EN
    chk("misalign_exc", 32'(misalign_exc_o), 32'(exp_exc));
`endif
    if (instr_v_o || m_halt) starve = 0;
    else starve++;
    if (starve > 300) begin
      chk("progress_cycles", starve, 0);
      starve = 0;
    end

    addr = bus.imem_addr_o;
    rsp  = rv && has_pend;
    branch_v_i         = br;
    pc_nxt_i           = tgt;
    bus.imem_gnt_i     = gn;
    bus.imem_rvalid_i  = rsp || stale_rv;
    bus.imem_rdata_i   = rsp ? memf(pend_addr) : $urandom;
    instr_ready_i      = rdy;

    g = bus.imem_req_o && gn;
    prev_hold = bus.imem_req_o && !gn && !br;
    prev_addr = addr;
    if (g && !br) begin
      chk("fetch_addr", addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rdy && mq.size() != 0 && !br) void'(mq.pop_front());
    if (rsp) begin
      if (!pend_disc && !br) mq.push_back(pend_addr);
      has_pend = 0;
    end
    if (g) begin
      has_pend  = 1;
      pend_addr = addr;
      pend_disc = br;
    end
    post_br = br;
    exp_exc = 0;
    if (br) begin
      mq.delete();
      if (has_pend) pend_disc = 1;
`ifdef IFETCH_MISALIGN_EXC_EN
      if (tgt[1:0] != 2'b00) begin
        m_halt  = 1;
        exp_exc = 1;
      end else begin
        m_halt    = 0;
        exp_fetch = tgt;
        br_tgt    = tgt;
      end
`else
      exp_fetch = tgt & 32'hFFFF_FFFC;
      br_tgt    = exp_fetch;
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n           = 1'b0;
    branch_v_i        = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    instr_ready_i     = 1'b0;
    mq.delete();
    has_pend = 0; pend_disc = 0; prev_hold = 0; post_br = 0; m_halt = 0; exp_exc = 0;
    exp_fetch = RESET_VECTOR;
    starve = 0;
    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req_o), 32'd0);
    chk("rst_instr_v", 32'(instr_v_o), 32'd0);
`ifdef IFETCH_MISALIGN_EXC_EN
    chk("rst_exc", 32'(misalign_exc_o), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    stale_rv = 0;
    do_reset();

    step(0, 0, 0, 0, 0);
    chk("first_req", 32'(bus.imem_req_o), 32'd1);
    chk("first_addr", bus.imem_addr_o, 32'h0000_1000);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("first_v", 32'(instr_v_o), 32'd1);
    chk("first_pc", pc_o, 32'h0000_1000);
    chk("first_instr", instr_o, 32'h0000_0013);

    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0);
    chk("full_req_low", 32'(bus.imem_req_o), 32'd0);
    chk("full_head_pc", pc_o, 32'h0000_1000);
    step(0, 0, 0, 0, 1);
    chk("second_pc", pc_o, 32'h0000_1004);
    step(0, 0, 0, 0, 1);

    step(0, 0, 1, 0, 0);
    step(1, 32'h0000_0100, 0, 0, 0);
    chk("br_wait_v", 32'(instr_v_o), 32'd0);
    chk("br_wait_req", 32'(bus.imem_req_o), 32'd0);
    step(0, 0, 0, 1, 0);
    chk("br_new_addr", bus.imem_addr_o, 32'h0000_0100);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("br_first_pc", pc_o, 32'h0000_0100);

    step(1, 32'h0000_0200, 1, 0, 1);
    chk("br_gnt_pop_v", 32'(instr_v_o), 32'd0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("br_gnt_pop_pc", pc_o, 32'h0000_0200);

    step(1, 32'hFFFF_FFFC, 0, 0, 0);
    chk("wrap_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("wrap_addr1", bus.imem_addr_o, 32'h0000_0000);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);

    step(1, 32'h0000_0102, 0, 0, 0);
`ifdef IFETCH_MISALIGN_EXC_EN
    chk("mis_exc", 32'(misalign_exc_o), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1);
    chk("mis_exc_end", 32'(misalign_exc_o), 32'd0);
    chk("mis_no_req", 32'(bus.imem_req_o), 32'd0);
`else
    chk("mis_addr", bus.imem_addr_o, 32'h0000_0100);
`endif
    step(1, 32'h0000_0300, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    do_reset();
    stale_rv = 1;
    step(0, 0, 0, 0, 0);
    stale_rv = 0;
    chk("stale_v", 32'(instr_v_o), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      case ($urandom_range(2))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        default: t = 32'($urandom_range(1023));
      endcase
      step($urandom_range(99) < 3, t, $urandom_range(9) < 6, $urandom_range(1) == 1,
           $urandom_range(9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, giving the number of fetched-instruction buffer entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port branch_v_i, input, 1, redirect request from the branch unit.
REQ-005 SHALL have port pc_nxt_i, input, XLEN, redirect target, sampled when branch_v_i=1.
REQ-006 SHALL have port imem_req_o, output, 1, fetch request valid.
REQ-007 SHALL have port imem_addr_o, output, XLEN, fetch address.
REQ-008 SHALL have port imem_gnt_i, input, 1, request accepted.
REQ-009 SHALL have port imem_rvalid_i, input, 1, response valid.
REQ-010 SHALL have port imem_rdata_i, input, 32, response instruction.
REQ-011 SHALL have port instr_v_o, output, 1, instruction valid to decode.
REQ-012 SHALL have port instr_o, output, 32, instruction at FIFO head.
REQ-013 SHALL have port pc_o, output, XLEN, PC of instr_o.
REQ-014 SHALL have port instr_ready_i, input, 1, decode accepts the head entry.
REQ-015 SHALL have port misalign_exc_o, output, 1, misaligned redirect flag; present only with IFETCH_MISALIGN_EXC_EN.

Function
REQ-016 SHALL hold fetch PC register pc_q; imem_addr_o equals pc_q.
REQ-017 SHALL use FSM states IDLE, REQ and WAIT_R, with at most one request outstanding.
- IDLE -> REQ when slots are free.
- REQ -> WAIT_R on imem_gnt_i.
- WAIT_R -> REQ or IDLE on imem_rvalid_i.
REQ-018 SHALL assert imem_req_o only in REQ, and hold imem_req_o and imem_addr_o stable until imem_gnt_i.
REQ-019 SHALL enter REQ only when FIFO occupancy plus the outstanding count is below FIFO_DEPTH.
REQ-020 SHALL increment pc_q by 4 (modulo 2^XLEN, wrapping) on every grant.
REQ-021 SHALL push {imem_rdata_i, request address} into the FIFO on imem_rvalid_i, unless the response is marked discard.
REQ-022 SHALL pop the FIFO on instr_v_o & instr_ready_i, and drive instr_v_o = FIFO not empty.
REQ-023 SHALL allow push and pop in the same cycle, including when the FIFO is full.
REQ-024 SHALL, on branch_v_i=1 at cycle t:
- load pc_q with pc_nxt_i;
- flush the FIFO, so instr_v_o=0 at t+1;
- return to REQ, so imem_req_o=1 with imem_addr_o=pc_nxt_i at t+1.
REQ-025 SHALL, if a request is granted but unanswered at a redirect, set a discard flag and drop that response without pushing; the new request waits in REQ until the discarded response returns.
REQ-026 SHALL, when a redirect and a grant occur in the same cycle, give priority to the redirect; the granted request becomes the discarded outstanding one.
REQ-027 SHALL, when a redirect and a pop occur in the same cycle, perform the flush and ignore the pop.
REQ-028 SHALL, if a REQ-state request is not yet granted at a redirect, replace its address (exception to REQ-018).

Reset
REQ-029 SHALL, while reset_n=0, set pc_q=RESET_VECTOR, FSM=IDLE, FIFO empty, discard flag cleared, and imem_req_o=0, instr_v_o=0, misalign_exc_o=0.
REQ-030 SHALL, on reset deassertion, issue the first request at RESET_VECTOR in the next cycle.
REQ-031 SHALL, on reset asserted mid-transaction, abandon any outstanding request and ignore any later rvalid for it.

Configuration
REQ-032 SHALL, with IFETCH_MISALIGN_EXC_EN defined, behave as follows on a redirect target with pc_nxt_i[1:0]!=0:
- pulse misalign_exc_o for one cycle at t+1;
- flush the FIFO;
- go to IDLE without fetching until the next redirect.
REQ-033 SHALL, without IFETCH_MISALIGN_EXC_EN, omit the misalign_exc_o port and clear pc_nxt_i[1:0] before loading pc_q.

Structure
REQ-034 SHALL take XLEN, RESET_VECTOR and the ifetch FSM state enum from package riscv.
REQ-035 SHALL place the FIFO in sub-module fetch_fifo, with push, pop, flush, full, empty and count.

Verification
REQ-036 Reset release -> imem_req_o=1, imem_addr_o=RESET_VECTOR next cycle; gnt/rvalid with 0x00000013 -> instr_v_o=1, pc_o=RESET_VECTOR.
REQ-037 instr_ready_i=0, memory always answering -> exactly FIFO_DEPTH entries at PCs RESET_VECTOR, +4; imem_req_o then held 0.
REQ-038 Redirect to 0x00000100 during WAIT_R -> stale rvalid not delivered; next instr_v_o has pc_o=0x00000100.
REQ-039 Redirect in the same cycle as imem_gnt_i and a pop -> FIFO empty next cycle; first delivered pc_o equals the redirect target.
REQ-040 pc_q=0xFFFFFFFC granted -> next request address is 0x00000000.
REQ-041 Redirect to 0x00000102 -> with the macro, misalign_exc_o pulses once and no requests follow; without it, fetch proceeds at 0x00000100.
